// File: rtl/player_sprite_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : player_sprite_reader_if
// Description : Bundles the animation inputs, raster position, sprite ROM
//               port and palette outputs of the player sprite reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface player_sprite_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
);
    logic              Frame_Clk;
    logic              Moving;
    logic [1:0]        Direction;
    logic [1:0]        Obj_Step_Count;
    logic [9:0]        PlayerX;
    logic [9:0]        PlayerY;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [DATA_W-1:0] Rom_Data;
    logic [ADDR_W-1:0] Rom_Addr;
    logic [3:0]        Frame_Index;
    logic [DATA_W-1:0] Pixel_Index;
    logic              Pixel_Valid;

    // Drives animation state, raster position and ROM data; observes outputs.
    modport master (
        output Frame_Clk, Moving, Direction, Obj_Step_Count,
        output PlayerX, PlayerY, DrawX, DrawY, Rom_Data,
        input  Rom_Addr, Frame_Index, Pixel_Index, Pixel_Valid
    );

    modport slave (
        input  Frame_Clk, Moving, Direction, Obj_Step_Count,
        input  PlayerX, PlayerY, DrawX, DrawY, Rom_Data,
        output Rom_Addr, Frame_Index, Pixel_Index, Pixel_Valid
    );
endinterface
`default_nettype wire

// File: rtl/player_sprite_reader.sv
`default_nettype none
// ============================================================================
// Module      : player_sprite_reader
// Description : Latches the player animation frame once per VGA frame and
//               fetches the sprite pixel under DrawX/DrawY from a synchronous
//               ROM, producing a palette index and draw-enable 3 clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
module player_sprite_reader #(
    parameter int                SPRITE_W    = 32,
    parameter int                SPRITE_H    = 32,
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 14,
    parameter logic [DATA_W-1:0] TRANSPARENT = 8'h00
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    player_sprite_reader_if.slave bus
);

    localparam int c_LOG_W   = $clog2(SPRITE_W);
    localparam int c_LOG_H   = $clog2(SPRITE_H);
    localparam int c_AW_FULL = 4 + c_LOG_H + c_LOG_W;

    // Frame edge detect and latched animation state
    logic                r_fc_d;
    logic [1:0]          r_dir_q;
    logic [1:0]          r_step_q;

    // Pipeline registers
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_v1;
    logic                r_v1_d;
    logic [DATA_W-1:0]   r_pix_idx;
    logic                r_pix_valid;

    // Stage 0 combinational terms
    logic                w_frame_rise;
    logic [10:0]         w_dx;
    logic [10:0]         w_dy;
    logic                w_in_x;
    logic                w_in_y;
    logic                w_in_box;
    logic [3:0]          w_frame_idx;
    logic [c_AW_FULL-1:0] w_addr_full;

    assign w_frame_rise = bus.Frame_Clk & ~r_fc_d;
    assign w_frame_idx  = {r_dir_q, r_step_q};

    assign w_dx = {1'b0, bus.DrawX} - {1'b0, bus.PlayerX};
    assign w_dy = {1'b0, bus.DrawY} - {1'b0, bus.PlayerY};

    // An 11-bit difference in [0, SPRITE-1] means Draw >= Player and
    // Draw < Player + SPRITE without wrapping past 1023.
    assign w_in_x   = (w_dx[10:c_LOG_W] == '0);
    assign w_in_y   = (w_dy[10:c_LOG_H] == '0);
    assign w_in_box = w_in_x & w_in_y;

    // Power-of-two sprite sizes turn (f*H + dy)*W + dx into a concatenation.
    assign w_addr_full = {w_frame_idx, w_dy[c_LOG_H-1:0], w_dx[c_LOG_W-1:0]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fc_d      <= 1'b0;
            r_dir_q     <= 2'd0;
            r_step_q    <= 2'd0;
            r_rom_addr  <= '0;
            r_v1        <= 1'b0;
            r_v1_d      <= 1'b0;
            r_pix_idx   <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_fc_d <= bus.Frame_Clk;
            if (w_frame_rise) begin
                r_dir_q  <= bus.Direction;
                r_step_q <= bus.Moving ? bus.Obj_Step_Count : 2'd0;
            end

            r_rom_addr <= w_in_box ? ADDR_W'(w_addr_full) : '0;
            r_v1       <= w_in_box;

            r_v1_d <= r_v1;

            r_pix_idx   <= r_v1_d ? bus.Rom_Data : TRANSPARENT;
            r_pix_valid <= r_v1_d && (bus.Rom_Data != TRANSPARENT);
        end
    end

    assign bus.Rom_Addr    = r_rom_addr;
    assign bus.Frame_Index = w_frame_idx;
    assign bus.Pixel_Index = r_pix_idx;
    assign bus.Pixel_Valid = r_pix_valid;

endmodule
`default_nettype wire

// File: tb/tb_player_sprite_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_sprite_reader
// Description : Self-checking bench for player_sprite_reader with a
//               behavioural sprite ROM and an output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_sprite_reader;

    logic Clk;
    logic Reset;

    player_sprite_reader_if #(.DATA_W(8), .ADDR_W(14)) bus();

    player_sprite_reader #(
        .SPRITE_W(32), .SPRITE_H(32), .DATA_W(8), .ADDR_W(14), .TRANSPARENT(8'h00)
    ) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int rom_mode;

    function automatic logic [7:0] rom_word(input logic [13:0] a);
        logic [7:0] w;
        if (rom_mode == 1) return 8'h05;
        w = a[7:0] ^ {a[13:8], 2'b01};
        if ((a % 7) == 0) w = 8'h00;
        return w;
    endfunction

    always @(posedge Clk) bus.Rom_Data <= rom_word(bus.Rom_Addr);

    typedef struct {
        logic       valid;
        logic [7:0] idx;
    } exp_t;

    typedef struct {
        logic [9:0]  px, py, dx, dy;
        logic        ein;
        logic [13:0] eaddr;
    } vec_t;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;
    logic       m_fcd;
    logic [3:0] m_fi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One pipelined pixel: push its expected result, clock, then compare.
    task automatic cycle(input logic ein, input logic [13:0] eaddr);
        exp_t e;
        logic rise;
        e.valid = ein && (rom_word(eaddr) != 8'h00);
        e.idx   = ein ? rom_word(eaddr) : 8'h00;
        q.push_back(e);
        rise  = bus.Frame_Clk && !m_fcd;
        m_fcd = bus.Frame_Clk;
        if (rise) m_fi = {bus.Direction, (bus.Moving ? bus.Obj_Step_Count : 2'd0)};
        @(posedge Clk); #1;
        chk("rom_addr", 32'(bus.Rom_Addr), 32'(eaddr));
        chk("frame_index", 32'(bus.Frame_Index), 32'(m_fi));
        if (q.size() == 3) begin
            e = q.pop_front();
            chk("pixel_valid", 32'(bus.Pixel_Valid), 32'(e.valid));
            chk("pixel_index", 32'(bus.Pixel_Index), 32'(e.idx));
        end
    endtask

    task automatic cycle_auto();
        int  dx, dy;
        logic ein;
        logic [13:0] a;
        dx  = int'(bus.DrawX) - int'(bus.PlayerX);
        dy  = int'(bus.DrawY) - int'(bus.PlayerY);
        ein = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
        a   = ein ? 14'((int'(m_fi) * 32 + dy) * 32 + dx) : 14'd0;
        cycle(ein, a);
    endtask

    task automatic reset_seq(input int n);
        exp_t z;
        Reset = 1'b1;
        q.delete();
        bus.PlayerX = 10'd100; bus.PlayerY = 10'd50;
        bus.DrawX   = 10'd105; bus.DrawY   = 10'd52;
        for (int i = 0; i < n; i++) begin
            bus.Frame_Clk = i[0];
            @(posedge Clk); #1;
            chk("rst_rom_addr", 32'(bus.Rom_Addr), 32'd0);
            chk("rst_frame_index", 32'(bus.Frame_Index), 32'd0);
            chk("rst_pixel_index", 32'(bus.Pixel_Index), 32'd0);
            chk("rst_pixel_valid", 32'(bus.Pixel_Valid), 32'd0);
        end
        Reset = 1'b0;
        bus.Frame_Clk = 1'b0;
        m_fcd = 1'b0;
        m_fi  = 4'd0;
        z.valid = 1'b0;
        z.idx   = 8'h00;
        q.push_back(z);
        q.push_back(z);
    endtask

    task automatic flush();
        bus.DrawY = 10'd600;
        bus.PlayerY = 10'd50;
        for (int i = 0; i < 3; i++) cycle_auto();
    endtask

    vec_t tbl[12];

    initial begin
        int cnt, run, max_run;
        n_cmp = 0;
        n_bad = 0;
        rom_mode = 0;
        m_fcd = 1'b0;
        m_fi  = 4'd0;
        bus.Moving = 1'b0; bus.Direction = 2'd0; bus.Obj_Step_Count = 2'd0;
        bus.Frame_Clk = 1'b0;

        tbl[0]  = '{10'd100,  10'd50,   10'd105,  10'd52,   1'b1, 14'd1093};
        tbl[1]  = '{10'd100,  10'd50,   10'd99,   10'd52,   1'b0, 14'd0};
        tbl[2]  = '{10'd100,  10'd50,   10'd131,  10'd81,   1'b1, 14'd2047};
        tbl[3]  = '{10'd100,  10'd50,   10'd132,  10'd52,   1'b0, 14'd0};
        tbl[4]  = '{10'd100,  10'd50,   10'd100,  10'd82,   1'b0, 14'd0};
        tbl[5]  = '{10'd100,  10'd50,   10'd100,  10'd50,   1'b1, 14'd1024};
        tbl[6]  = '{10'd1000, 10'd50,   10'd1023, 10'd52,   1'b1, 14'd1111};
        tbl[7]  = '{10'd1000, 10'd50,   10'd0,    10'd52,   1'b0, 14'd0};
        tbl[8]  = '{10'd1000, 10'd1000, 10'd1010, 10'd1023, 1'b1, 14'd1770};
        tbl[9]  = '{10'd1000, 10'd1000, 10'd1010, 10'd0,    1'b0, 14'd0};
        tbl[10] = '{10'd0,    10'd0,    10'd0,    10'd0,    1'b1, 14'd1024};
        tbl[11] = '{10'd0,    10'd0,    10'd31,   10'd31,   1'b1, 14'd2047};

        reset_seq(3);

        // Frame latch: one pulse per rise, hold between rises, idle -> stance
        bus.PlayerX = 10'd100; bus.PlayerY = 10'd50; bus.DrawX = 10'd0; bus.DrawY = 10'd600;
        bus.Moving = 1'b1; bus.Direction = 2'd3; bus.Obj_Step_Count = 2'd2;
        bus.Frame_Clk = 1'b1;
        cycle_auto();
        chk("frame_E", 32'(bus.Frame_Index), 32'h E);
        bus.Direction = 2'd0; bus.Obj_Step_Count = 2'd1;
        cycle_auto(); cycle_auto();
        bus.Frame_Clk = 1'b0;
        cycle_auto();
        chk("frame_E_hold", 32'(bus.Frame_Index), 32'h E);
        bus.Moving = 1'b0; bus.Direction = 2'd3; bus.Obj_Step_Count = 2'd3;
        bus.Frame_Clk = 1'b1;
        cycle_auto();
        chk("frame_C", 32'(bus.Frame_Index), 32'h C);
        bus.Frame_Clk = 1'b0;
        cycle_auto();

        // Select frame 1 for the hand-computed address table
        bus.Moving = 1'b1; bus.Direction = 2'd0; bus.Obj_Step_Count = 2'd1;
        bus.Frame_Clk = 1'b1;
        cycle_auto();
        bus.Frame_Clk = 1'b0;
        cycle_auto();
        chk("frame_1", 32'(bus.Frame_Index), 32'h1);

        for (int i = 0; i < 12; i++) begin
            bus.PlayerX = tbl[i].px; bus.PlayerY = tbl[i].py;
            bus.DrawX   = tbl[i].dx; bus.DrawY   = tbl[i].dy;
            cycle(tbl[i].ein, tbl[i].eaddr);
        end
        flush();

        // Row sweep with an opaque ROM: exactly 32 contiguous valid pixels
        rom_mode = 1;
        bus.PlayerX = 10'd100; bus.PlayerY = 10'd50; bus.DrawY = 10'd50;
        cnt = 0; run = 0; max_run = 0;
        for (int x = 99; x <= 135; x++) begin
            bus.DrawX = 10'(x);
            if (x > 132) bus.DrawY = 10'd600;
            cycle_auto();
            if (bus.Pixel_Valid === 1'b1) begin
                cnt++; run++;
                if (run > max_run) max_run = run;
            end else run = 0;
        end
        chk("sweep_valid_count", 32'(cnt), 32'd32);
        chk("sweep_valid_run", 32'(max_run), 32'd32);
        rom_mode = 0;

        // Row with transparent words interleaved back-to-back
        bus.DrawY = 10'd52;
        for (int x = 100; x <= 131; x++) begin
            bus.DrawX = 10'(x);
            cycle_auto();
        end
        flush();

        // Reset in the middle of a row drops in-flight pixels
        bus.DrawY = 10'd60;
        for (int x = 100; x <= 110; x++) begin
            bus.DrawX = 10'(x);
            cycle_auto();
        end
        reset_seq(2);
        bus.PlayerX = 10'd100; bus.PlayerY = 10'd50; bus.DrawY = 10'd60;
        for (int x = 111; x <= 120; x++) begin
            bus.DrawX = 10'(x);
            cycle_auto();
        end

        // Random positions around the sprite with random frame changes
        for (int i = 0; i < 300; i++) begin
            if ((i % 20) == 0) begin
                bus.PlayerX = 10'($urandom_range(0, 1023));
                bus.PlayerY = 10'($urandom_range(0, 1023));
            end
            bus.DrawX = 10'(int'(bus.PlayerX) + int'($urandom_range(0, 40)) - 4);
            bus.DrawY = 10'(int'(bus.PlayerY) + int'($urandom_range(0, 40)) - 4);
            bus.Frame_Clk = ($urandom_range(0, 7) == 0);
            bus.Moving = 1'($urandom_range(0, 1));
            bus.Direction = 2'($urandom_range(0, 3));
            bus.Obj_Step_Count = 2'($urandom_range(0, 3));
            cycle_auto();
        end
        bus.Frame_Clk = 1'b0;
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_sprite_reader.md
Name: player_sprite_reader

Overview:
- Consumer side of the player walk-step counter: takes the 2-bit step index, movement flag and facing direction, and reads the matching player sprite frame out of a synchronous sprite ROM for the pixel currently being drawn.
- Latches animation state once per VGA frame so a sprite frame never tears mid-scan.
- Pipelines the ROM fetch against DrawX/DrawY.
- Emits a palette index plus a draw-enable to the colour mapper.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of 2)
- SPRITE_H, 32, sprite height in pixels (power of 2)
- DATA_W, 8, ROM word width (palette index)
- ADDR_W, 14, ROM address width; must hold 16*SPRITE_W*SPRITE_H words
- TRANSPARENT, 8'h00, palette index treated as see-through

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Frame_Clk  in  1  VGA vsync-derived frame signal, level; rising edge marks new frame
- Moving  in  1  player is walking this frame
- Direction  in  2  facing: 0 down, 1 up, 2 left, 3 right
- Obj_Step_Count  in  2  walk step index from the step counter
- PlayerX  in  10  sprite top-left X
- PlayerY  in  10  sprite top-left Y
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- Rom_Data  in  DATA_W  sprite ROM read data, valid 1 clk after Rom_Addr
- Rom_Addr  out  ADDR_W  sprite ROM read address
- Frame_Index  out  4  latched {Dir_q, Step_q}
- Pixel_Index  out  DATA_W  palette index of current pixel
- Pixel_Valid  out  1  draw player pixel (inside box and not transparent)

Behaviour:
- Reset: Rom_Addr=0, Frame_Index=0, Pixel_Index=0, Pixel_Valid=0, edge-detect register=0, all pipeline valid bits=0. Reset asserted mid-operation discards in-flight pixels the same cycle.
- Frame edge detect:
  - Fc_d registers Frame_Clk.
  - frame_rise = Frame_Clk & ~Fc_d, a one-clock pulse per rising edge.
  - A Frame_Clk held high yields exactly one pulse.
- On frame_rise:
  - Dir_q <= Direction.
  - Step_q <= Moving ? Obj_Step_Count : 2'd0, so an idle player always shows the stance frame.
  - Between pulses, Dir_q and Step_q hold regardless of input changes.
  - Frame_Index = {Dir_q, Step_q}.
- Stage 0 (combinational):
  - dx = DrawX - PlayerX and dy = DrawY - PlayerY, both computed at 11 bits.
  - in_box = DrawX>=PlayerX && DrawX<PlayerX+SPRITE_W && DrawY>=PlayerY && DrawY<PlayerY+SPRITE_H.
  - Sums are computed at 11 bits, so a sprite near the X/Y=1023 edge does not wrap. Pixels beyond 1023 are never in_box.
- Stage 1 (registered):
  - Rom_Addr <= in_box ? ((Frame_Index*SPRITE_H + dy)*SPRITE_W + dx) : 0.
  - v1 <= in_box.
  - The address uses the Frame_Index value current at the cycle of the register update.
- ROM: synchronous, returns Rom_Data one clock after Rom_Addr.
- Stage 2 (registered):
  - Pixel_Index <= Rom_Data.
  - Pixel_Valid <= v1_d && (Rom_Data != TRANSPARENT), where v1_d is v1 delayed one clock.
  - When v1_d=0, Pixel_Index <= TRANSPARENT.
- Latency: DrawX/DrawY sampled at cycle N drives Pixel_Valid/Pixel_Index at cycle N+3 register output, i.e. valid after the third rising edge. The pipeline is fully pipelined, accepting a new pixel every clock with no stalls.
- Simultaneous frame_rise and in-box pixel: stage 1 uses the old Frame_Index that cycle and the new one from the next cycle. frame_rise falls in vertical blanking, so no visible tear.
- ROM layout: frame f = Dir*4+Step occupies words [f*SPRITE_W*SPRITE_H, (f+1)*SPRITE_W*SPRITE_H-1], row-major.

Test Plan:
- Reset held 3 clks with Frame_Clk toggling and DrawX/DrawY inside the sprite -> every output 0 throughout. First Pixel_Valid occurs no earlier than 3 clks after Reset deasserts.
- Moving=1, Direction=3, Obj_Step_Count=2, one Frame_Clk rise -> Frame_Index=4'hE. Changing inputs without another rise leaves 4'hE. Moving=0 at the next rise -> Frame_Index=4'hC.
- PlayerX=100, PlayerY=50, DrawX=105, DrawY=52, Frame_Index=4'h1 -> Rom_Addr=(1*32+2)*32+5=1093 one clk later. Pixel_Index equals the ROM word at 1093 three clks after the sample.
- DrawX stepping 99..132 on row DrawY=50 with ROM all 8'h05 -> Pixel_Valid high for exactly 32 consecutive clks, covering DrawX 100..131 delayed by 3.
- ROM word returns TRANSPARENT inside the box -> Pixel_Valid=0, Pixel_Index=8'h00. The next non-transparent pixel asserts Pixel_Valid immediately, back-to-back.
- PlayerX=1000, DrawX=1023 -> in_box true, Rom_Addr uses dx=23. DrawX=0 in the same row -> in_box false (no wrap).
